// File: rtl/shift_arbiter.sv
// shift_arbiter: two requesters share one funnel-shift datapath. Each cycle one
// requester is granted (round-robin or fixed priority), its operand is shifted and
// the result is captured in a one-entry output stage tagged with the requester id.
//
// Optional feature: define SHIFT_ARB_STATS_EN to build saturating per-requester
// grant counters. Without it, grant_cnt0/grant_cnt1 are tied to zero.
//
// Parameters:
//   W   data width (shift amount is $clog2(W)+1 bits)
//   RR  1 = round-robin, 0 = fixed priority (req0 wins)
//
// Ports:
//   clk, rst                          clock (rising edge), async active-high reset
//   req{0,1}_valid/ready              request handshake (ready is combinational)
//   req{0,1}_data/n/op                operand, shift amount, op (00 LSR 01 ASR 10 LSL 11 ROR)
//   resp_valid/ready                  output stage handshake
//   resp_data, resp_id                registered result and issuing requester
//   grant_cnt0, grant_cnt1            grant counters (zero unless SHIFT_ARB_STATS_EN)
module shift_arbiter #(
    parameter int unsigned W  = 8,
    parameter bit          RR = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [W-1:0]           req0_data,
    input  logic [$clog2(W):0]     req0_n,
    input  logic [1:0]             req0_op,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [W-1:0]           req1_data,
    input  logic [$clog2(W):0]     req1_n,
    input  logic [1:0]             req1_op,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [W-1:0]           resp_data,
    output logic                   resp_id,
    output logic [15:0]            grant_cnt0,
    output logic [15:0]            grant_cnt1
);

    localparam int unsigned NW = $clog2(W) + 1;

    localparam logic [1:0] OpLsr = 2'b00;
    localparam logic [1:0] OpAsr = 2'b01;
    localparam logic [1:0] OpLsl = 2'b10;
    localparam logic [1:0] OpRor = 2'b11;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   data_q;
    logic           id_q;
    logic           last_grant_q;

    logic           acc;
    logic           gnt;
    logic           xfer;
    logic [W-1:0]   sel_data;
    logic [NW-1:0]  sel_n;
    logic [1:0]     sel_op;
    logic [W-1:0]   hi, lo;
    logic [NW-1:0]  k;
    logic [2*W-1:0] funnel;
    logic [W-1:0]   shift_res;

    // A new request can land if the stage is empty or is being drained this cycle.
    assign acc = (state_q == StEmpty) | resp_ready;

    always_comb begin
        gnt = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt = RR ? ~last_grant_q : 1'b0;
        end else if (req1_valid) begin
            gnt = 1'b1;
        end
    end

    assign req0_ready = acc & req0_valid & ~gnt;
    assign req1_ready = acc & req1_valid & gnt;
    assign xfer       = req0_ready | req1_ready;

    assign sel_data = gnt ? req1_data : req0_data;
    assign sel_n    = gnt ? req1_n    : req0_n;
    assign sel_op   = gnt ? req1_op   : req0_op;

    // Funnel shifter: result is the low W bits of {hi,lo} >> k.
    always_comb begin
        hi = '0;
        lo = sel_data;
        k  = sel_n;
        unique case (sel_op)
            OpLsr: begin
                // Clamp so any n >= W empties the word.
                if (sel_n >= NW'(W)) k = NW'(W);
            end
            OpAsr: begin
                hi = {W{sel_data[W-1]}};
                // Beyond W the funnel would run past the sign fill; clamp at W.
                if (sel_n >= NW'(W)) k = NW'(W);
            end
            OpLsl: begin
                if (sel_n >= NW'(W)) begin
                    hi = '0;
                    lo = '0;
                    k  = '0;
                end else begin
                    hi = sel_data;
                    lo = '0;
                    k  = NW'(W) - sel_n;
                end
            end
            OpRor: begin
                hi = sel_data;
                k  = sel_n % NW'(W);
            end
            default: ;
        endcase
    end

    assign funnel    = {hi, lo};
    assign shift_res = W'(funnel >> k);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: if (xfer) state_d = StFull;
            StFull:  if (resp_ready && !xfer) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StEmpty;
            data_q       <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                data_q       <= shift_res;
                id_q         <= gnt;
                last_grant_q <= gnt;
            end
        end
    end

    assign resp_valid = (state_q == StFull);
    assign resp_data  = data_q;
    assign resp_id    = id_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    // Saturating: a counter parks at 0xFFFF rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready && cnt0_q != 16'hFFFF) cnt0_q <= cnt0_q + 16'd1;
            if (req1_ready && cnt1_q != 16'hFFFF) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 8-bit funnel-shift datapath between two requesters.
- Supports logical right, arithmetic right, logical left and rotate right.
- Arbitrates between the two requesters each cycle, computes the result, registers it in a one-entry output stage, and returns it tagged with the requester id.
- Sits between the ALU issue logic (two ports) and the writeback path.

Parameters:
W, 8, data width; shift amount width is $clog2(W)+1.
RR, 1, 1 = round-robin arbitration, 0 = fixed priority (req0 wins).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 has a request
req0_ready  out  1  requester 0 request accepted this cycle
req0_data  in  W  operand
req0_n  in  $clog2(W)+1  shift amount
req0_op  in  2  00 LSR, 01 ASR, 10 LSL, 11 ROR
req1_valid, req1_ready, req1_data, req1_n, req1_op  same as req0, for requester 1
resp_valid  out  1  result held in output stage
resp_ready  in  1  consumer takes result
resp_data  out  W  shifted result
resp_id  out  1  requester that issued the result
grant_cnt0  out  16  grants to requester 0 (optional feature)
grant_cnt1  out  16  grants to requester 1 (optional feature)

Behaviour:
- Reset (async, rst=1): resp_valid=0, resp_data=0, resp_id=0, last_grant=1 (req0 favoured first), grant counters=0, state EMPTY. Reset mid-transaction drops the held result silently.
- FSM states:
  - EMPTY: output stage empty.
  - FULL: resp_valid=1, result held stable until resp_ready=1.
- Can-accept condition: acc = (state==EMPTY) | resp_ready.
  - req0_ready / req1_ready are combinational.
  - Only the granted requester sees ready=1, and only when acc=1.
- Arbitration:
  - Only one valid: it wins.
  - Both valid and RR=1: the requester not equal to last_grant wins.
  - Both valid and RR=0: req0 always wins.
  - last_grant updates only on an actual transfer (valid & ready).
- Transfer at edge t: resp_data/resp_id load at t, resp_valid=1 from t+1 (latency 1 cycle).
- State transitions:
  - EMPTY + transfer -> FULL.
  - FULL + resp_ready + transfer -> FULL with new data (back-to-back, full throughput).
  - FULL + resp_ready + no transfer -> EMPTY.
  - FULL + !resp_ready -> FULL; no request is accepted and data is held.
- Requester data/n/op are sampled only on transfer. Inputs need not stay stable after acceptance.
- Arithmetic (n = shift amount):
  - LSR: data >> n, zeros shifted in.
  - ASR: data >> n, data[W-1] replicated.
  - LSL: data << n, zeros shifted in.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - Implemented as a funnel {hi,lo} >> k:
    - LSR: hi=0, lo=data, k=n.
    - ASR: hi={W{msb}}, lo=data, k=n.
    - LSL: hi=data, lo=0, k=W-n.
    - ROR: hi=lo=data, k=n.
- Shift-amount boundaries:
  - n=0: unchanged for all ops.
  - n>=W with LSR/LSL: 0.
  - n>=W with ASR: all copies of the sign bit.
  - ROR: uses n mod W.
- Simultaneous valid on both requesters with acc=0: neither gets ready; last_grant does not change.

Optional Feature:
- Macro SHIFT_ARB_STATS_EN.
- Defined: grant_cnt0/grant_cnt1 increment on each transfer from the respective requester. They saturate at 0xFFFF (no wrap) and reset to 0.
- Undefined: the counter logic is not compiled, and both ports are tied to 0.

Test Plan:
- req0 data=0x96, n=3, all four ops in sequence, resp_ready=1 -> resp_data 0x12 (LSR), 0xF2 (ASR), 0xB0 (LSL), 0xD2 (ROR). Each has resp_id=0 and appears 1 cycle after acceptance.
- Boundaries, data=0x96:
  - n=8: LSR -> 0x00, ASR -> 0xFF, LSL -> 0x00, ROR -> 0x96.
  - n=0 with any op -> 0x96.
  - n=11 with ROR -> 0xD2.
- Both requesters valid continuously, RR=1, resp_ready=1 -> grants alternate 0,1,0,1 starting with 0. With RR=0 -> always 0, and req1_ready stays 0.
- Backpressure: resp_ready=0 for 4 cycles after the first result -> resp_data/resp_id stable, both ready outputs 0. On resp_ready=1 the next request is accepted in the same cycle, with no bubble.
- Assert rst while FULL -> resp_valid drops immediately (async), grants restart with req0, counters read 0.
- With SHIFT_ARB_STATS_EN: 5 grants to req0 and 3 to req1 -> grant_cnt0=5, grant_cnt1=3. Without the macro, both read 0.
